// File: rtl/tpu_bank_pkg.sv
// Shared types and address helpers for the TPU SRAM bank arbiter.
// Bank index is the low-order address bits; the row is the bits above them.
package tpu_bank_pkg;

  localparam int DEFAULT_NUM_BANKS = 8;
  localparam int DEFAULT_DEPTH     = 4096;
  localparam int BANK_BITS         = $clog2(DEFAULT_NUM_BANKS);
  localparam int ROW_W             = $clog2(DEFAULT_DEPTH) - BANK_BITS;

  // {set, bank} as driven on the physical SRAM interface
  typedef logic [BANK_BITS:0] phys_bank_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } swap_state_e;

  function automatic logic [31:0] bank_of(input logic [31:0] addr,
                                          input int unsigned bank_bits);
    return addr & ((32'd1 << bank_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] row_of(input logic [31:0] addr,
                                         input int unsigned bank_bits,
                                         input int unsigned row_w);
    return (addr >> bank_bits) & ((32'd1 << row_w) - 32'd1);
  endfunction

endpackage

// File: rtl/tpu_bank_swap_fsm.sv
// Active/shadow swap sequencer: drains the read pipe, flips active_set, pulses swap_ack.
// hold is high in DRAIN and SWAP and blocks all new grants.
module tpu_bank_swap_fsm
  import tpu_bank_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic swap_req,
  input  logic rd_outstanding,
  output logic hold,
  output logic swap_ack,
  output logic active_set
);

  swap_state_e state_q, state_d;
  logic        active_set_q, active_set_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    active_set_d = active_set_q;
    unique case (state_q)
      IDLE:  if (swap_req) state_d = DRAIN;
      DRAIN: if (!rd_outstanding) begin
        state_d      = SWAP;
        active_set_d = ~active_set_q;
      end
      SWAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      active_set_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_set_q <= active_set_d;
    end
  end

  assign hold       = (state_q != IDLE);
  assign swap_ack   = (state_q == SWAP);
  assign active_set = active_set_q;

endmodule

// File: rtl/tpu_bank_arbiter.sv
// Per-cycle DMA-write / controller-read arbiter in front of interleaved, double-buffered SRAM banks.
// Optional macro TPU_BANK_STARVE_GUARD_EN lets a starved DMA win after STARVE_LIMIT stalls.
module tpu_bank_arbiter
  import tpu_bank_pkg::*;
#(
  parameter  int NUM_BANKS    = DEFAULT_NUM_BANKS,
  parameter  int DEPTH        = DEFAULT_DEPTH,
  parameter  int DATA_W       = 32,
  parameter  int STARVE_LIMIT = 4,
  localparam int ADDR_W       = $clog2(DEPTH),
  localparam int BANK_IDX_W   = $clog2(NUM_BANKS),
  localparam int ROW_IDX_W    = ADDR_W - BANK_IDX_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dma_wvalid,
  output logic                  dma_wready,
  input  logic [ADDR_W:0]       dma_waddr,
  input  logic [DATA_W-1:0]     dma_wdata,
  input  logic                  dma_direct,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_W:0]       rd_addr,
  output logic                  rd_rvalid,
  output logic [DATA_W-1:0]     rd_rdata,
  output logic                  mem_we,
  output logic [BANK_IDX_W:0]   mem_wbank,
  output logic [ROW_IDX_W-1:0]  mem_wrow,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_re,
  output logic [BANK_IDX_W:0]   mem_rbank,
  output logic [ROW_IDX_W-1:0]  mem_rrow,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  active_set,
  input  logic                  cnt_clear,
  output logic [31:0]           conflict_cnt,
  output logic                  error
);

  if (NUM_BANKS < 2 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_banks
    $error("NUM_BANKS must be a power of two >= 2");
  end
  if (DEPTH <= NUM_BANKS || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two larger than NUM_BANKS");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_starve
    $error("STARVE_LIMIT must be at least 1");
  end

  logic                 hold, w_oor, r_oor, w_set, conflict, dma_wins, rd_fire, w_fire;
  logic [BANK_IDX_W:0]  w_pbank, r_pbank;
  logic [ROW_IDX_W-1:0] w_row, r_row;
  logic                 rvalid_q, rvalid_d, rd_oor_q, rd_oor_d, error_q, error_d;
  logic [31:0]          conflict_cnt_q, conflict_cnt_d;

  tpu_bank_swap_fsm u_swap_fsm (
    .clk           (clk),
    .rst_n         (rst_n),
    .swap_req      (swap_req),
    .rd_outstanding(rd_fire),
    .hold          (hold),
    .swap_ack      (swap_ack),
    .active_set    (active_set)
  );

  assign w_oor   = dma_waddr[ADDR_W];
  assign r_oor   = rd_addr[ADDR_W];
  assign w_set   = dma_direct ? active_set : ~active_set;
  assign w_pbank = {w_set, BANK_IDX_W'(bank_of(32'(dma_waddr), BANK_IDX_W))};
  assign r_pbank = {active_set, BANK_IDX_W'(bank_of(32'(rd_addr), BANK_IDX_W))};
  assign w_row   = ROW_IDX_W'(row_of(32'(dma_waddr), BANK_IDX_W, ROW_IDX_W));
  assign r_row   = ROW_IDX_W'(row_of(32'(rd_addr), BANK_IDX_W, ROW_IDX_W));

  // Out-of-range requests never touch a bank, so they cannot collide.
  assign conflict = !hold && dma_wvalid && rd_valid && !w_oor && !r_oor
                    && (w_pbank == r_pbank);

  assign rd_ready   = rd_valid && !hold && !dma_wins;
  assign dma_wready = dma_wvalid && !hold && !(conflict && !dma_wins);
  assign rd_fire    = rd_valid && rd_ready;
  assign w_fire     = dma_wvalid && dma_wready;

`ifdef TPU_BANK_STARVE_GUARD_EN
  localparam int STALL_W = $clog2(STARVE_LIMIT + 1);
  logic [STALL_W-1:0] stall_q, stall_d;

  assign dma_wins = conflict && (stall_q >= STALL_W'(STARVE_LIMIT));

  always_comb begin
    stall_d = stall_q;
    if (w_fire)        stall_d = '0;
    else if (conflict) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end
`else
  assign dma_wins = 1'b0;
`endif

  always_comb begin
    rvalid_d       = rd_fire;
    rd_oor_d       = rd_fire && r_oor;
    error_d        = error_q || (w_fire && w_oor) || (rd_fire && r_oor);
    conflict_cnt_d = conflict_cnt_q;
    if (cnt_clear)                               conflict_cnt_d = '0;
    else if (conflict && (conflict_cnt_q != '1)) conflict_cnt_d = conflict_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q       <= 1'b0;
      rd_oor_q       <= 1'b0;
      error_q        <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      rvalid_q       <= rvalid_d;
      rd_oor_q       <= rd_oor_d;
      error_q        <= error_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign mem_we    = w_fire && !w_oor;
  assign mem_wbank = mem_we ? w_pbank : '0;
  assign mem_wrow  = mem_we ? w_row : '0;
  assign mem_wdata = mem_we ? dma_wdata : '0;
  assign mem_re    = rd_fire && !r_oor;
  assign mem_rbank = mem_re ? r_pbank : '0;
  assign mem_rrow  = mem_re ? r_row : '0;

  assign rd_rvalid    = rvalid_q;
  assign rd_rdata     = (rvalid_q && !rd_oor_q) ? mem_rdata : '0;
  assign conflict_cnt = conflict_cnt_q;
  assign error        = error_q;

endmodule

// File: tb/tb_tpu_bank_arbiter.sv
// Directed bench for tpu_bank_arbiter with a 1-cycle-latency SRAM model.
// Build with TPU_BANK_STARVE_GUARD_EN to exercise the starvation guard.
`timescale 1ns/1ps
module tb_tpu_bank_arbiter;
  import tpu_bank_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              dma_wvalid, dma_wready, dma_direct;
  logic [12:0]       dma_waddr, rd_addr;
  logic [31:0]       dma_wdata, rd_rdata, mem_wdata, mem_rdata, conflict_cnt;
  logic              rd_valid, rd_ready, rd_rvalid;
  logic              mem_we, mem_re, swap_req, swap_ack, active_set, cnt_clear, error;
  phys_bank_t        mem_wbank, mem_rbank;
  logic [8:0]        mem_wrow, mem_rrow;
  logic [31:0]       sram [0:8191];
  int                total = 0;
  int                bad = 0;

  always #5 clk = ~clk;

  tpu_bank_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .dma_wvalid(dma_wvalid), .dma_wready(dma_wready), .dma_waddr(dma_waddr),
    .dma_wdata(dma_wdata), .dma_direct(dma_direct),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .mem_we(mem_we), .mem_wbank(mem_wbank), .mem_wrow(mem_wrow), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_rbank(mem_rbank), .mem_rrow(mem_rrow), .mem_rdata(mem_rdata),
    .swap_req(swap_req), .swap_ack(swap_ack), .active_set(active_set),
    .cnt_clear(cnt_clear), .conflict_cnt(conflict_cnt), .error(error)
  );

  always @(posedge clk) begin
    if (mem_we) sram[{mem_wbank, mem_wrow}] <= mem_wdata;
    if (mem_re) mem_rdata <= sram[{mem_rbank, mem_rrow}];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    dma_wvalid = 1'b0;
    rd_valid   = 1'b0;
    swap_req   = 1'b0;
    cnt_clear  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 8192; i++) sram[i] = '0;
    mem_rdata  = '0;
    idle_inputs();
    dma_waddr  = '0;
    dma_wdata  = '0;
    dma_direct = 1'b0;
    rd_addr    = '0;

    // reset state
    #12;
    check("rst_wready", 32'(dma_wready), 32'd0);
    check("rst_rready", 32'(rd_ready), 32'd0);
    check("rst_rvalid", 32'(rd_rvalid), 32'd0);
    check("rst_active", 32'(active_set), 32'd0);
    check("rst_ack", 32'(swap_ack), 32'd0);
    check("rst_cnt", conflict_cnt, 32'd0);
    check("rst_err", 32'(error), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // no conflict: shadow write bank 1, active read bank 2
    dma_wvalid = 1'b1; dma_waddr = 13'h001; dma_wdata = 32'hAAAA_AAAA; dma_direct = 1'b0;
    rd_valid = 1'b1; rd_addr = 13'h002;
    settle();
    check("nc_wready", 32'(dma_wready), 32'd1);
    check("nc_rready", 32'(rd_ready), 32'd1);
    check("nc_wbank", 32'(mem_wbank), 32'd9);
    check("nc_rbank", 32'(mem_rbank), 32'd2);
    check("nc_re", 32'(mem_re), 32'd1);
    step();
    idle_inputs();
    check("nc_rvalid", 32'(rd_rvalid), 32'd1);
    check("nc_cnt", conflict_cnt, 32'd0);
    step();
    check("nc_rvalid_pulse", 32'(rd_rvalid), 32'd0);

    // conflict: direct write 0x008 vs read 0x010, both set 0 bank 0
    dma_wvalid = 1'b1; dma_waddr = 13'h008; dma_wdata = 32'h1234_5678; dma_direct = 1'b1;
    rd_valid = 1'b1; rd_addr = 13'h010;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("cf_rready", 32'(rd_ready), 32'd1);
      check("cf_wready", 32'(dma_wready), 32'd0);
      check("cf_we", 32'(mem_we), 32'd0);
      step();
    end
    check("cf_cnt3", conflict_cnt, 32'd3);
    rd_valid = 1'b0;
    settle();
    check("cf_rel_wready", 32'(dma_wready), 32'd1);
    check("cf_rel_wbank", 32'(mem_wbank), 32'd0);
    check("cf_rel_wrow", 32'(mem_wrow), 32'd1);
    step();
    idle_inputs();

    // two shadow writes, then swap with nothing outstanding
    dma_wvalid = 1'b1; dma_direct = 1'b0; dma_waddr = 13'h001; dma_wdata = 32'hAAAA_AAAA;
    settle();
    check("sw_w1_bank", 32'(mem_wbank), 32'd9);
    step();
    dma_waddr = 13'h003; dma_wdata = 32'h5555_5555;
    settle();
    check("sw_w2_bank", 32'(mem_wbank), 32'd11);
    step();
    idle_inputs();
    swap_req = 1'b1;
    settle();
    check("sw_ack_n", 32'(swap_ack), 32'd0);
    step();
    swap_req = 1'b0; rd_valid = 1'b1; rd_addr = 13'h001;
    settle();
    check("sw_ack_n1", 32'(swap_ack), 32'd0);
    check("sw_hold_n1", 32'(rd_ready), 32'd0);
    step();
    settle();
    check("sw_ack_n2", 32'(swap_ack), 32'd1);
    check("sw_hold_n2", 32'(rd_ready), 32'd0);
    step();
    settle();
    check("sw_ack_n3", 32'(swap_ack), 32'd0);
    check("sw_active", 32'(active_set), 32'd1);
    check("sw_rd_ready", 32'(rd_ready), 32'd1);
    check("sw_rbank", 32'(mem_rbank), 32'd9);
    step();
    check("sw_rb1_valid", 32'(rd_rvalid), 32'd1);
    check("sw_rb1_data", rd_rdata, 32'hAAAA_AAAA);
    rd_addr = 13'h003;
    settle();
    check("sw_b2b_ready", 32'(rd_ready), 32'd1);
    step();
    check("sw_rb2_valid", 32'(rd_rvalid), 32'd1);
    check("sw_rb2_data", rd_rdata, 32'h5555_5555);

    // swap requested in the same cycle a read is accepted
    swap_req = 1'b1;
    settle();
    check("sp_rready_n", 32'(rd_ready), 32'd1);
    step();
    swap_req = 1'b0; rd_addr = 13'h008;
    dma_wvalid = 1'b1; dma_waddr = 13'h005; dma_wdata = 32'hCAFE_0005; dma_direct = 1'b1;
    check("sp_rvalid_n1", 32'(rd_rvalid), 32'd1);
    check("sp_rdata_n1", rd_rdata, 32'h5555_5555);
    settle();
    check("sp_rready_n1", 32'(rd_ready), 32'd0);
    check("sp_wready_n1", 32'(dma_wready), 32'd0);
    check("sp_ack_n1", 32'(swap_ack), 32'd0);
    step();
    settle();
    check("sp_ack_n2", 32'(swap_ack), 32'd1);
    check("sp_rready_n2", 32'(rd_ready), 32'd0);
    check("sp_wready_n2", 32'(dma_wready), 32'd0);
    step();
    settle();
    check("sp_ack_n3", 32'(swap_ack), 32'd0);
    check("sp_active", 32'(active_set), 32'd0);
    check("sp_rready_n3", 32'(rd_ready), 32'd1);
    check("sp_wready_n3", 32'(dma_wready), 32'd1);
    step();
    idle_inputs();
    check("sp_rd8_data", rd_rdata, 32'h1234_5678);

    // out-of-range read and write
    rd_valid = 1'b1; rd_addr = 13'h1000;
    settle();
    check("oor_rready", 32'(rd_ready), 32'd1);
    check("oor_re", 32'(mem_re), 32'd0);
    check("oor_err_before", 32'(error), 32'd0);
    step();
    idle_inputs();
    check("oor_rvalid", 32'(rd_rvalid), 32'd1);
    check("oor_rdata", rd_rdata, 32'd0);
    check("oor_err", 32'(error), 32'd1);
    dma_wvalid = 1'b1; dma_waddr = 13'h1008; dma_direct = 1'b1;
    rd_valid = 1'b1; rd_addr = 13'h008;
    settle();
    check("oor_wready", 32'(dma_wready), 32'd1);
    check("oor_we", 32'(mem_we), 32'd0);
    check("oor_nocf_rready", 32'(rd_ready), 32'd1);
    step();
    idle_inputs();
    check("oor_nocf_cnt", conflict_cnt, 32'd3);
    check("oor_rd_data", rd_rdata, 32'h1234_5678);
    step();
    step();
    check("oor_err_sticky", 32'(error), 32'd1);

    // counter saturation and clear priority
    force dut.conflict_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.conflict_cnt_q;
    dma_wvalid = 1'b1; dma_waddr = 13'h008; dma_direct = 1'b1;
    rd_valid = 1'b1; rd_addr = 13'h010;
    step();
    check("sat_ff", conflict_cnt, 32'hFFFF_FFFF);
    step();
    check("sat_hold", conflict_cnt, 32'hFFFF_FFFF);
    cnt_clear = 1'b1;
    step();
    check("clr_prio", conflict_cnt, 32'd0);
    cnt_clear = 1'b0; rd_valid = 1'b0;
    settle();
    check("clr_grant", 32'(dma_wready), 32'd1);
    step();
    check("clr_cnt_idle", conflict_cnt, 32'd0);

    // persistent conflict: five cycles
    rd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("stv_rready", 32'(rd_ready), 32'd1);
      check("stv_wready", 32'(dma_wready), 32'd0);
      step();
    end
    settle();
`ifdef TPU_BANK_STARVE_GUARD_EN
    check("stv5_wready", 32'(dma_wready), 32'd1);
    check("stv5_rready", 32'(rd_ready), 32'd0);
`else
    check("stv5_wready", 32'(dma_wready), 32'd0);
    check("stv5_rready", 32'(rd_ready), 32'd1);
`endif
    step();
    idle_inputs();
    check("stv_cnt5", conflict_cnt, 32'd5);

    // reset mid-read and mid-swap
    rd_valid = 1'b1; rd_addr = 13'h008; swap_req = 1'b1;
    settle();
    rst_n = 1'b0;
    idle_inputs();
    step();
    check("ar_rvalid", 32'(rd_rvalid), 32'd0);
    check("ar_err", 32'(error), 32'd0);
    check("ar_cnt", conflict_cnt, 32'd0);
    rst_n = 1'b1;
    step();
    step();
    check("ar_ack", 32'(swap_ack), 32'd0);
    check("ar_active", 32'(active_set), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
